// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame
// geometry (also used by uart_tx) and a small majority-vote helper.
package uart_pkg;

   // Default ticks per bit and data bits per frame for the UART pair.
   localparam int DEF_OVERSAMPLE = 16;
   localparam int DEF_DATA_BITS  = 8;

   // Receiver state encoding.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BRK   = 3'd4
   } rx_state_e;

   // 2-of-3 majority, used to reject single-sample noise on a bit.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage : uart_pkg

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous pin inputs. Both flops reset to
// RESET_VAL so an idle-high line does not look like activity after reset.
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   // Shift the raw pin through two flops to settle metastability.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         // NOTE: non-blocking assignments so sync_q takes the old meta_q;
         // blocking here would collapse the chain into a single flop.
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule : sync2

// File: rtl/uart_rx.sv
// Oversampling 8N1 UART receiver. The serial pin is synchronized, each bit
// is decided by a 3-sample majority vote around the bit centre, and each
// completed byte is offered on a valid/ready handshake. Frame state only
// advances on the OVERSAMPLE x baud tick enable; the handshake runs every
// clock. OVERSAMPLE must be even and >= 6; DATA_BITS must be 5..8.
module uart_rx
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = DEF_OVERSAMPLE,
   parameter int DATA_BITS  = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick,
   input  logic                 serrx,
   output logic [DATA_BITS-1:0] dout,
   output logic                 valid,
   input  logic                 ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   // Sample-counter geometry: votes at H-1, H, H+1, decision at H+1.
   localparam int H    = OVERSAMPLE / 2;
   localparam int SC_W = $clog2(OVERSAMPLE);
   localparam int BC_W = $clog2(DATA_BITS);

   localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
   localparam logic [SC_W-1:0] SC_V0   = SC_W'(H - 1);
   localparam logic [SC_W-1:0] SC_V1   = SC_W'(H);
   localparam logic [SC_W-1:0] SC_DEC  = SC_W'(H + 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   // Synchronized serial line.
   logic rxs;

   // Frame state and its next-state values.
   rx_state_e            state_q, state_d;
   logic [SC_W-1:0]      sc_q, sc_d;
   logic [BC_W-1:0]      bc_q, bc_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic                 vs0_q, vs0_d;
   logic                 vs1_q, vs1_d;

   // Output-side registers.
   logic [DATA_BITS-1:0] dout_q;
   logic                 valid_q;
   logic                 frame_err_q;
   logic                 overrun_q;

   // Per-cycle events from the frame FSM.
   logic vote;
   logic complete;
   logic stop_err;

   sync2 #(
      .RESET_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d_i (serrx),
      .q_o (rxs)
   );

   // The third vote sample is the live line at the decision tick.
   assign vote = maj3(vs0_q, vs1_q, rxs);

   // Frame state register: start/data/stop tracking and vote samples.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sc_q    <= '0;
         bc_q    <= '0;
         // NOTE: the shift register is cleared on reset as well, so dout can
         // never be loaded from an uninitialised value after a reset.
         shreg_q <= '0;
         vs0_q   <= 1'b1;
         vs1_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         sc_q    <= sc_d;
         bc_q    <= bc_d;
         shreg_q <= shreg_d;
         vs0_q   <= vs0_d;
         vs1_q   <= vs1_d;
      end
   end

   // Next-state logic: everything holds unless this cycle carries a tick.
   always_comb begin
      // NOTE: every variable gets its hold value first, so no branch can
      // leave one unassigned and infer a latch.
      state_d  = state_q;
      sc_d     = sc_q;
      bc_d     = bc_q;
      shreg_d  = shreg_q;
      vs0_d    = vs0_q;
      vs1_d    = vs1_q;
      complete = 1'b0;
      stop_err = 1'b0;

      if (tick) begin
         // Inside a frame the sample counter free-runs and captures votes.
         if (state_q inside {START, DATA, STOP}) begin
            if (sc_q == SC_V0) vs0_d = rxs;
            if (sc_q == SC_V1) vs1_d = rxs;
            sc_d = (sc_q == SC_LAST) ? '0 : sc_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_d = START;
                  sc_d    = '0;
               end
            end

            START: begin
               if (sc_q == SC_DEC && vote) begin
                  // Line was high at the bit centre: a glitch, not a start.
                  state_d = IDLE;
                  sc_d    = '0;
               end else if (sc_q == SC_LAST) begin
                  state_d = DATA;
                  bc_d    = '0;
               end
            end

            DATA: begin
               if (sc_q == SC_DEC) begin
                  shreg_d = {vote, shreg_q[DATA_BITS-1:1]};
               end
               if (sc_q == SC_LAST) begin
                  if (bc_q == BC_LAST) begin
                     state_d = STOP;
                  end else begin
                     bc_d = bc_q + 1'b1;
                  end
               end
            end

            STOP: begin
               // Finish at the stop-bit centre so the next start edge is
               // never missed, even when the sender runs slightly fast.
               if (sc_q == SC_DEC) begin
                  sc_d = '0;
                  if (vote) begin
                     state_d  = IDLE;
                     complete = 1'b1;
                  end else begin
                     state_d  = BRK;
                     stop_err = 1'b1;
                  end
               end
            end

            BRK: begin
               // Wait out a held-low line so a break reports only once.
               if (rxs) begin
                  state_d = IDLE;
               end
            end

            default: begin
               state_d = IDLE;
               sc_d    = '0;
            end
         endcase
      end
   end

   // Output handshake: load on completion, clear on consume, flag overrun.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dout_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= stop_err;
         overrun_q   <= complete && valid_q && !ready;
         if (complete) begin
            // A new byte replaces whatever is held; a simultaneous accept
            // simply consumes the old byte, so valid stays high.
            dout_q  <= shreg_q;
            valid_q <= 1'b1;
         end else if (valid_q && ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q != IDLE);

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: OVERSAMPLE = 16, one tick every 4 clocks,
// so a nominal bit lasts 64 clocks. Inputs change on the falling edge and
// outputs are observed on the falling edge.
module tb_uart_rx;

   localparam int OS      = 16;
   localparam int DB      = 8;
   localparam int H       = OS / 2;
   localparam int BIT_CLK = 4 * OS;
   // Ticks from start detection to the stop-bit decision tick.
   localparam int DEC_TICKS = 1 + OS * (DB + 1) + (H + 1);

   logic          clk   = 1'b0;
   logic          rst   = 1'b1;
   logic          tick  = 1'b0;
   logic          serrx = 1'b1;
   logic          ready = 1'b0;
   logic [DB-1:0] dout;
   logic          valid;
   logic          frame_err;
   logic          overrun;
   logic          busy;

   int n_cmp = 0;
   int n_mis = 0;

   // Monitor accumulators, written only by the monitor process.
   logic [7:0] rx_q[$];
   int fe_cnt    = 0;
   int ov_cnt    = 0;
   int valid_cnt = 0;
   int busy_cnt  = 0;
   int tick_ph   = 0;

   uart_rx #(
      .OVERSAMPLE (OS),
      .DATA_BITS  (DB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .serrx     (serrx),
      .dout      (dout),
      .valid     (valid),
      .ready     (ready),
      .frame_err (frame_err),
      .overrun   (overrun),
      .busy      (busy)
   );

   initial forever #5 clk = ~clk;

   // Tick enable: one clock high out of every four.
   initial begin
      forever begin
         @(negedge clk);
         tick    = (tick_ph == 3);
         tick_ph = (tick_ph + 1) % 4;
      end
   end

   // Monitor: accepted bytes and pulse/level counts.
   initial begin
      forever begin
         @(negedge clk);
         if (valid && ready) rx_q.push_back(dout);
         if (frame_err) fe_cnt++;
         if (overrun)   ov_cnt++;
         if (valid)     valid_cnt++;
         if (busy)      busy_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] rx_at(input int idx);
      if (idx < rx_q.size()) return rx_q[idx];
      return 'x;
   endfunction

   // Drive one 8N1 frame with the given bit length and stop-bit level.
   task automatic send_frame(input logic [7:0] b, input int bclk, input logic stop_v);
      serrx = 1'b0;
      repeat (bclk) @(negedge clk);
      for (int i = 0; i < DB; i++) begin
         serrx = b[i];
         repeat (bclk) @(negedge clk);
      end
      serrx = stop_v;
      repeat (bclk) @(negedge clk);
      serrx = 1'b1;
   endtask

   initial begin
      int         base_rx;
      int         base_fe;
      int         base_ov;
      int         base_v;
      int         base_b;
      int         waited;
      int         periods[3];
      logic [7:0] exp_b;

      periods[0] = BIT_CLK;
      periods[1] = 62;
      periods[2] = 66;

      // Reset state.
      rst   = 1'b1;
      serrx = 1'b1;
      ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset dout", dout, 8'h00);
      check("reset valid", valid, 1'b0);
      check("reset frame_err", frame_err, 1'b0);
      check("reset overrun", overrun, 1'b0);
      check("reset busy", busy, 1'b0);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("idle ticks keep idle", busy, 1'b0);

      // Single frame 0x61.
      ready   = 1'b1;
      base_rx = rx_q.size();
      base_fe = fe_cnt;
      base_ov = ov_cnt;
      base_v  = valid_cnt;
      send_frame(8'h61, BIT_CLK, 1'b1);
      repeat (16) @(negedge clk);
      check("0x61 count", rx_q.size() - base_rx, 1);
      check("0x61 data", rx_at(base_rx), 8'h61);
      check("0x61 one valid pulse", valid_cnt - base_v, 1);
      check("0x61 frame_err", fe_cnt - base_fe, 0);
      check("0x61 overrun", ov_cnt - base_ov, 0);

      // Back-to-back 'a'..'z' at nominal, fast and slow bit periods.
      for (int p = 0; p < 3; p++) begin
         base_rx = rx_q.size();
         base_fe = fe_cnt;
         base_ov = ov_cnt;
         for (int c = 0; c < 26; c++) begin
            exp_b = 8'h61 + 8'(c);
            send_frame(exp_b, periods[p], 1'b1);
         end
         repeat (32) @(negedge clk);
         check("burst count", rx_q.size() - base_rx, 26);
         for (int c = 0; c < 26; c++) begin
            exp_b = 8'h61 + 8'(c);
            check("burst byte", rx_at(base_rx + c), exp_b);
         end
         check("burst frame_err", fe_cnt - base_fe, 0);
         check("burst overrun", ov_cnt - base_ov, 0);
      end

      // Four-tick low glitch on the idle line.
      base_v = valid_cnt;
      base_b = busy_cnt;
      serrx  = 1'b0;
      repeat (16) @(negedge clk);
      serrx = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      check("glitch busy seen", (busy_cnt - base_b) > 0, 1'b1);
      check("glitch busy bound", (busy_cnt - base_b) <= 4 * (H + 2), 1'b1);
      check("glitch no valid", valid_cnt - base_v, 0);
      check("glitch back idle", busy, 1'b0);

      // 0x55 with a low stop bit, then a break of three frame times.
      base_fe = fe_cnt;
      base_v  = valid_cnt;
      send_frame(8'h55, BIT_CLK, 1'b0);
      serrx = 1'b0;
      repeat (3 * 10 * BIT_CLK) @(negedge clk);
      check("break busy", busy, 1'b1);
      serrx = 1'b1;
      repeat (2 * BIT_CLK) @(negedge clk);
      check("break one frame_err", fe_cnt - base_fe, 1);
      check("break no valid", valid_cnt - base_v, 0);
      check("break back idle", busy, 1'b0);
      base_rx = rx_q.size();
      send_frame(8'hA5, BIT_CLK, 1'b1);
      repeat (16) @(negedge clk);
      check("post-break count", rx_q.size() - base_rx, 1);
      check("post-break data", rx_at(base_rx), 8'hA5);
      check("post-break frame_err", fe_cnt - base_fe, 1);

      // Overrun with ready low.
      ready   = 1'b0;
      base_ov = ov_cnt;
      send_frame(8'h31, BIT_CLK, 1'b1);
      repeat (16) @(negedge clk);
      check("hold valid", valid, 1'b1);
      check("hold dout", dout, 8'h31);
      check("no overrun yet", ov_cnt - base_ov, 0);
      send_frame(8'h32, BIT_CLK, 1'b1);
      repeat (16) @(negedge clk);
      check("overrun dout", dout, 8'h32);
      check("overrun valid", valid, 1'b1);
      check("overrun one pulse", ov_cnt - base_ov, 1);

      // Completion in the same cycle as an accept: no overrun.
      base_ov = ov_cnt;
      fork
         send_frame(8'h33, BIT_CLK, 1'b1);
         begin
            waited = 0;
            while (!busy && waited < 4 * BIT_CLK) begin
               @(negedge clk);
               waited++;
            end
            check("coincide start seen", busy, 1'b1);
            repeat (4 * DEC_TICKS - 1) @(negedge clk);
            check("coincide pre busy", busy, 1'b1);
            ready = 1'b1;
            @(negedge clk);
            ready = 1'b0;
            check("coincide done", busy, 1'b0);
            check("coincide dout", dout, 8'h33);
            check("coincide valid", valid, 1'b1);
            check("coincide no overrun", ov_cnt - base_ov, 0);
         end
      join
      repeat (8) @(negedge clk);
      ready = 1'b1;
      repeat (2) @(negedge clk);
      check("consume clears valid", valid, 1'b0);
      check("consume holds dout", dout, 8'h33);

      // Reset during data bit 3 of 0x0F.
      serrx = 1'b0;
      repeat (BIT_CLK) @(negedge clk);
      serrx = 1'b1;
      repeat (3 * BIT_CLK + BIT_CLK / 2) @(negedge clk);
      check("pre-reset busy", busy, 1'b1);
      check("pre-reset dout", dout, 8'h33);
      #1 rst = 1'b1;
      #1;
      check("async rst dout", dout, 8'h00);
      check("async rst valid", valid, 1'b0);
      check("async rst busy", busy, 1'b0);
      check("async rst frame_err", frame_err, 1'b0);
      check("async rst overrun", overrun, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (2 * BIT_CLK) @(negedge clk);
      base_rx = rx_q.size();
      base_fe = fe_cnt;
      send_frame(8'h0F, BIT_CLK, 1'b1);
      repeat (16) @(negedge clk);
      check("post-reset count", rx_q.size() - base_rx, 1);
      check("post-reset data", rx_at(base_rx), 8'h0F);
      check("post-reset frame_err", fe_cnt - base_fe, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_uart_rx
